// File: rtl/uart_rx_port.sv
// uart_rx_port
//   Memory-mapped UART receiver. Samples the asynchronous UART_RX line,
//   assembles frames into a small receive FIFO and exposes them through three
//   word registers starting at BASE_ADDR. The interrupt is held high while IE
//   is set and received data is waiting.
//
// Parameters
//   BAUD_DIV   clk cycles per serial bit (>= 4)
//   FIFO_DEPTH receive FIFO entries (power of two, 2..16)
//   BASE_ADDR  byte address of RXDATA; STATUS = +4, CONTROL = +8
//
// Ports
//   clk      core clock, rising edge
//   reset    asynchronous, active-low reset
//   rd, wr   bus read / write strobes, held for the whole access cycle
//   addr     byte address (exact match on the three registers)
//   wdata    write data
//   rdata    combinational read data, 0 when not reading a register
//   UART_RX  asynchronous serial input, idles high
//   irqout   level interrupt = IE & FIFO not empty
//
// Register map
//   RXDATA  (R)   {24'b0, FIFO head}; a read pops the FIFO
//   STATUS  (R)   [12:8] count, [4] PERR, [3] FERR, [2] OVR, [1] FULL, [0] NE
//           (W)   write-1-to-clear on bits [4:2]
//   CONTROL (R/W) [0] IE, [1] FLUSH (self-clearing, reads 0)
//
// Build option
//   UART_RX_PARITY_EN  defined: 8E1 frames with PERR checking
//                      undefined: 8N1 frames, PERR always reads 0
module uart_rx_port #(
  parameter int          BAUD_DIV   = 2604,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        UART_RX,
  output logic        irqout
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_FIFO_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  logic          rx_meta, rx_sync, rx_prev;
  logic [2:0]    settle;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [2:0]    flags;
  logic          ie;

  logic stop_fire, ferr_set, perr_set, push_req;
  logic sel_data, sel_stat, sel_ctrl;
  logic ne, full, pop, push, flush, ovr_set;
  logic [2:0] w1c;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:5];

  // The synchronizer flops reset high, so right after reset they carry a
  // fake "idle" level. settle marks when rx_prev holds a genuine sample, so a
  // line that is still low from an aborted frame cannot look like a new
  // falling edge until it has really risen and fallen again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 3'b000;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      settle  <= {settle[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (settle[2] && rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits.
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bad <= rx_sync ^ (^shreg);
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit outcome; FERR wins over PERR because PERR needs a good stop bit.
  always_comb begin
    stop_fire = (state == STOP) && (cnt == FULL_M1);
    ferr_set  = stop_fire && !rx_sync;
`ifdef UART_RX_PARITY_EN
    perr_set  = stop_fire && rx_sync && par_bad;
`else
    perr_set  = 1'b0;
`endif
    push_req  = stop_fire && rx_sync && !perr_set;
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO is still
  // accepted then; FLUSH overrides everything and leaves the FIFO empty.
  always_comb begin
    sel_data = (addr == BASE_ADDR);
    sel_stat = (addr == BASE_ADDR + 32'd4);
    sel_ctrl = (addr == BASE_ADDR + 32'd8);
    ne       = (count != '0);
    full     = (count == DEPTH);
    pop      = rd && sel_data && ne;
    flush    = wr && sel_ctrl && wdata[1];
    push     = push_req && (!full || pop) && !flush;
    ovr_set  = push_req && full && !pop;
    w1c      = (wr && sel_stat) ? wdata[4:2] : 3'b000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_FIFO_ONE;
        2'b01:   count <= count - CNT_FIFO_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shreg;
  end

  // New error events are OR-ed in after the W1C mask so they are never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 3'b000;
      ie    <= 1'b0;
    end else begin
      flags <= (flags & ~w1c) | {perr_set, ferr_set, ovr_set};
      if (wr && sel_ctrl) ie <= wdata[0];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      if (sel_data && ne)
        rdata = {24'd0, mem[rptr]};
      else if (sel_stat)
        rdata = {19'd0, 5'(count), 3'd0, flags, full, ne};
      else if (sel_ctrl)
        rdata = {31'd0, ie};
    end
  end

  assign irqout = ie && ne;

endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Memory-mapped UART receiver peripheral that answers the CPU's load/store bus as a responder. It samples the serial `UART_RX` line and assembles 8-bit frames into a small receive FIFO. It exposes data, status and control words at fixed addresses in the 0x4000_0000 peripheral window and raises a level interrupt while received data is pending. It runs on the CPU core clock `clk`.

## Interface

- `BAUD_DIV`, 2604, clk cycles per serial bit; 25 MHz / 9600 baud; minimum 4.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, 2..16.
- `BASE_ADDR`, 32'h4000_0018, byte address of RXDATA; STATUS = base+4, CONTROL = base+8.

Ports:

- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; low clears all state immediately.
- `rd` in 1: bus read strobe; held high for the whole instruction cycle.
- `wr` in 1: bus write strobe; same timing as `rd`.
- `addr` in 32: byte address; only exact word matches on the three registers respond.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data; 0 when `rd` is low or the address is unmatched.
- `UART_RX` in 1: asynchronous serial input; idles high.
- `irqout` out 1: level interrupt.

## Operation

- **Input sync.** `UART_RX` passes through a 2-flop synchronizer, reset value 1. All FSM decisions use the synchronized value.
- **Receive FSM** (bit counter `cnt` counts 0..BAUD_DIV-1):
  - IDLE: a high-to-low transition of the synchronized line goes to START with `cnt` = 0.
  - START: at `cnt` = BAUD_DIV/2-1, sample the line. Low goes to DATA (frame accepted). High goes to IDLE (glitch rejected; no flag).
  - DATA: every BAUD_DIV cycles, sample and shift in LSB first. After 8 bits go to PARITY (macro on) or STOP.
  - PARITY: one bit period; sampled bit is checked for even parity against the data byte.
  - STOP: one bit period, then sample.
    - Sample 1 and FIFO not full: push the byte.
    - Sample 1 and FIFO full: drop the byte and set OVR.
    - Sample 0: drop the byte and set FERR.
    - Parity mismatch (macro on): drop the byte and set PERR. FERR takes precedence if both apply.
    - All outcomes return to IDLE.
- **Registers.**
  - RXDATA (read): returns {24'b0, FIFO head}, or 0 if empty. When `rd` is high at a clock edge and the FIFO is non-empty, the FIFO pops. Writes are ignored.
  - STATUS (read):
    - bit0 NE (FIFO not empty)
    - bit1 FULL
    - bit2 OVR
    - bit3 FERR
    - bit4 PERR
    - bits[12:8] entry count
  - STATUS (write): W1C on bits [4:2].
  - CONTROL (read/write): bit0 IE; bit1 FLUSH, self-clearing, which empties the FIFO on that edge and always reads 0.
- **Interrupt.** `irqout` = IE & NE, registered-free (combinational from state).
- **Reset values:**
  - FIFO empty; flags 0; IE 0; FSM IDLE.
  - `irqout` 0; `rdata` 0.

## Timing

- Sample points fall at the bit centres: start + BAUD_DIV/2, then every BAUD_DIV cycles.
- NE rises on the edge after the stop-bit sample. This is about 2 + BAUD_DIV/2 + 9·BAUD_DIV cycles after the line falls (10·BAUD_DIV with parity).
- Reads are zero-wait: `rdata` is valid in the same cycle as `rd`, and the pop commits on the closing edge.
- Push and pop in the same edge:
  - Count is unchanged.
  - If the FIFO is full, the push is accepted and OVR is not set.
  - If the FIFO is empty, the push still occurs and the read returns 0.
- FLUSH together with a push: the FIFO ends empty.
- W1C together with a new error event: the flag ends set.
- Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame aborts the frame. Once reset releases, the synchronizer reads high, so a line still low mid-frame cannot start a frame until it rises and falls again.

## Configuration

- `UART_RX_PARITY_EN`:
  - Defined: frames are 8E1. The PARITY state is present and PERR is live.
  - Undefined: frames are 8N1. There is no PARITY state and STATUS bit4 reads 0.

## Test plan

All scenarios use BAUD_DIV = 16 and FIFO_DEPTH = 4.

- **Reset:** drive `reset` low mid-frame -> `irqout` = 0, STATUS reads 0x0, FSM IDLE; a subsequent frame 0x5A is received correctly.
- **Single frame:** send 0xA5 with IE = 1 -> STATUS = 0x101 and `irqout` = 1 within 2+8+144 cycles of the falling edge; reading RXDATA returns 0xA5, then STATUS = 0x0 and `irqout` = 0.
- **Overflow:** send 5 bytes 0x01..0x05 with no reads -> STATUS = 0x406 (count 4, FULL, OVR); four reads return 0x01..0x04; writing 0x4 to STATUS clears OVR.
- **Glitch and framing errors:**
  - A 4-cycle low pulse produces no data and no flags.
  - A frame whose stop bit is 0 sets FERR (STATUS = 0x8) and pushes nothing.
- **Boundaries:**
  - RXDATA read with the FIFO full on the same edge as a stop-bit push -> count stays 4, OVR stays 0.
  - A FLUSH write leaves count 0.
- **Parity (macro defined):** 0x03 with parity bit 0 is accepted; 0x03 with parity bit 1 sets PERR and pushes nothing.
